// File: rtl/bsearch_pkg.sv
// Shared types and constants for the binary-search controller.
// Compare codes match the one-hot output of the magnitude comparator.
package bsearch_pkg;

    localparam int W_DEF = 20;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_t;

endpackage

// File: rtl/bsearch_ctrl.sv
// Successive-approximation search controller driving the comparator
// guess side; narrows [lo, hi] by halving until hit or exhaustion.
module bsearch_ctrl
    import bsearch_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = $clog2(W + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  lo_in,
    input  logic [W-1:0]  hi_in,
    output logic [W-1:0]  guess,
    output logic          guess_vld,
    input  logic [2:0]    cmp,
    input  logic          cmp_vld,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [W-1:0]  result,
    output logic [IW-1:0] iters,
    output logic          err
);

    state_t state, state_nx;

    // One extra bit so lo can step past the top of the range.
    logic [W:0] lo, hi;
    logic [W:0] mid, lo_up, hi_dn;
    logic       accept, step;

    assign mid    = lo + ((hi - lo) >> 1);
    assign lo_up  = mid + 1'b1;
    assign hi_dn  = mid - 1'b1;
    assign accept = (state == S_IDLE) && start;
    assign step   = (state == S_PROBE) && cmp_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (lo_in > hi_in) ? S_DONE : S_PROBE;
                end
            end
            S_PROBE: begin
                if (cmp_vld) begin
                    case (cmp)
                        CMP_EQ: state_nx = S_DONE;
                        CMP_LT: begin
                            if (lo_up > hi) state_nx = S_DONE;
                        end
                        CMP_GT: begin
                            if (mid == '0 || lo > hi_dn) state_nx = S_DONE;
                        end
                        default: state_nx = S_DONE;
                    endcase
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        guess_vld = (state == S_PROBE);
        busy      = (state == S_PROBE);
        done      = (state == S_DONE);
        guess     = guess_vld ? mid[W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo     <= '0;
            hi     <= '0;
            iters  <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else if (accept) begin
            lo     <= {1'b0, lo_in};
            hi     <= {1'b0, hi_in};
            iters  <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else if (step) begin
            iters <= iters + IW'(1);
            case (cmp)
                CMP_EQ: begin
                    result <= mid[W-1:0];
                    found  <= 1'b1;
                end
                CMP_LT: lo <= lo_up;
                CMP_GT: begin
                    if (mid != '0) hi <= hi_dn;
                end
                default: err <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Scoreboard bench for bsearch_ctrl against a behavioural comparator.
// Expectations are pushed at start; a monitor pops on each done pulse.
module tb_bsearch_ctrl;

    localparam int W  = 20;
    localparam int IW = $clog2(W + 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  lo_in, hi_in;
    logic [W-1:0]  guess;
    logic          guess_vld;
    logic [2:0]    cmp;
    logic          cmp_vld;
    logic          busy, done, found, err;
    logic [W-1:0]  result;
    logic [IW-1:0] iters;

    logic [W-1:0]  target;
    logic          cmp_force;
    logic [2:0]    cmp_ovr;

    assign cmp = cmp_force ? cmp_ovr
               : {guess < target, guess == target, guess > target};

    bsearch_ctrl #(.W(W), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lo_in(lo_in), .hi_in(hi_in),
        .guess(guess), .guess_vld(guess_vld),
        .cmp(cmp), .cmp_vld(cmp_vld),
        .busy(busy), .done(done), .found(found),
        .result(result), .iters(iters), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          found;
        logic          chk_res;
        logic [W-1:0]  result;
        logic [IW-1:0] iters;
        logic          err;
        int            done_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   dones = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            dones++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done, expected none");
            end else begin
                e = sb.pop_front();
                check("found", found, e.found);
                check("iters", iters, e.iters);
                check("err", err, e.err);
                check("busy_at_done", busy, 1'b0);
                if (e.chk_res) check("result", result, e.result);
                if (e.done_cyc >= 0) check("done_cycle", cyc, e.done_cyc);
            end
        end
    end

    task automatic push(input logic f, input logic cr, input logic [W-1:0] r,
                        input logic [IW-1:0] it, input logic e, input int dc);
        exp_t x;
        x.found    = f;
        x.chk_res  = cr;
        x.result   = r;
        x.iters    = it;
        x.err      = e;
        x.done_cyc = dc;
        sb.push_back(x);
    endtask

    // Returns #1 after the sampling edge; sc is the cycle stamp there.
    task automatic go(input logic [W-1:0] l, input logic [W-1:0] h,
                      input logic [W-1:0] t, output int sc);
        @(negedge clk);
        lo_in  = l;
        hi_in  = h;
        target = t;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sc    = cyc;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done, expected done", name);
        end
        @(negedge clk);
    endtask

    initial begin
        int sc;
        rst_n     = 1'b0;
        start     = 1'b0;
        lo_in     = '0;
        hi_in     = '0;
        target    = '0;
        cmp_vld   = 1'b1;
        cmp_force = 1'b0;
        cmp_ovr   = 3'b000;
        #12;
        check("reset_outputs",
              {guess, guess_vld, busy, done, found, result, iters, err}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full range, target 0: twenty probes.
        go(20'd0, 20'd1048575, 20'd0, sc);
        check("first_guess", guess, 20'd524287);
        check("vld_busy", {guess_vld, busy, done}, 3'b110);
        push(1'b1, 1'b1, 20'd0, 5'd20, 1'b0, sc + 20);
        wait_done("t0");

        // Midpoint hit on the first probe.
        go(20'd0, 20'd1048575, 20'd524287, sc);
        push(1'b1, 1'b1, 20'd524287, 5'd1, 1'b0, sc + 1);
        wait_done("mid");

        // Target below range.
        go(20'd10, 20'd20, 20'd5, sc);
        push(1'b0, 1'b0, 20'd0, 5'd3, 1'b0, sc + 3);
        check("below_g1", guess, 20'd15);
        @(posedge clk);
        #1;
        check("below_g2", guess, 20'd12);
        @(posedge clk);
        #1;
        check("below_g3", guess, 20'd10);
        wait_done("below");

        // Top of range: lo climbs to the maximum without wrapping.
        go(20'd0, 20'd1048575, 20'd1048575, sc);
        push(1'b1, 1'b1, 20'd1048575, 5'd21, 1'b0, sc + 21);
        wait_done("max");

        // Stall for four cycles, then an illegal code.
        @(negedge clk);
        cmp_vld = 1'b0;
        go(20'd0, 20'd1000, 20'd700, sc);
        check("stall_g0", guess, 20'd500);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_guess", {guess_vld, guess}, {1'b1, 20'd500});
            check("stall_iters", iters, 5'd0);
        end
        push(1'b0, 1'b0, 20'd0, 5'd1, 1'b1, -1);
        cmp_force = 1'b1;
        cmp_ovr   = 3'b000;
        cmp_vld   = 1'b1;
        wait_done("illegal");
        check("done_single", done, 1'b0);
        cmp_force = 1'b0;

        // Reset on the third probe, then inverted bounds.
        go(20'd0, 20'd1048575, 20'd0, sc);
        repeat (3) @(negedge clk);
        check("pre_reset_iters", iters, 5'd2);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {guess, guess_vld, busy, done, found, result, iters, err}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        go(20'd5, 20'd4, 20'd0, sc);
        push(1'b0, 1'b0, 20'd0, 5'd0, 1'b0, sc);
        check("inv_vld", {guess_vld, done}, 2'b01);
        wait_done("inv");

        check("sb_empty", sb.size(), 0);
        check("done_count", dones, 6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsearch_ctrl.md
# bsearch_ctrl

Successive-approximation search controller that drives the guess side of the 20-bit magnitude comparator and consumes its 3-bit one-hot result. It locates an unknown target value within a loaded range `[lo, hi]` by binary search. Each probe presents a guess and waits for a compare code. The block sits upstream of the comparator in the game/datapath and reports the found value, a found/not-found flag and the probe count.

## Interface

**Parameters**

- `W`, default 20: data width; must match the comparator width.
- `IW`, default `$clog2(W+2)`: width of the probe counter.

**Ports**

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: start request, sampled in IDLE only.
- `lo_in` input W: lower search bound, captured on an accepted start.
- `hi_in` input W: upper search bound, captured on an accepted start.
- `guess` output W: current probe value, driven to the comparator `a` side.
- `guess_vld` output 1: `guess` is valid and awaiting a compare result.
- `cmp` input 3: compare code `{guess<target, guess==target, guess>target}`.
- `cmp_vld` input 1: `cmp` is valid this cycle; tie high for a combinational comparator.
- `busy` output 1: search in progress.
- `done` output 1: one-cycle completion pulse.
- `found` output 1: the target lies in range and `result` is valid.
- `result` output W: located value.
- `iters` output IW: number of probes issued.
- `err` output 1: an illegal compare code was received.

## Operation

- States: IDLE, PROBE, DONE.
- **IDLE**, on `start`:
  - Capture `lo`/`hi` into W+1-bit registers.
  - Clear `iters`, `found`, `err`; set `busy`.
  - If `lo_in > hi_in`, go to DONE with `found=0`. Otherwise go to PROBE.
- **PROBE**:
  - `guess = lo + ((hi - lo) >> 1)`, computed in W+1 bits with no overflow.
  - `guess_vld = 1`.
  - On a cycle where `cmp_vld=1`, increment `iters` and act on `cmp`:
    - `3'b010` (EQ): `result=guess`, `found=1`, go to DONE.
    - `3'b100` (LT, guess below target): `lo = guess + 1`.
    - `3'b001` (GT): if `guess == 0`, go to DONE with `found=0`; else `hi = guess - 1`.
    - Any other code: `err=1`, `found=0`, go to DONE.
  - After an LT or GT update, if `lo > hi`, go to DONE with `found=0`. Otherwise stay in PROBE with a new guess.
- **DONE**: `done=1` and `busy=0` for exactly one cycle, then return to IDLE.
- `result`, `found`, `iters` and `err` hold their values until the next accepted start.
- `start` is ignored outside IDLE.
- The probe count never exceeds W+1, so `iters` never wraps.

## Timing

- Reset values: `guess=0`, `guess_vld=0`, `busy=0`, `done=0`, `found=0`, `result=0`, `iters=0`, `err=0`; state IDLE.
- Start sampled at edge N: `busy` and `guess_vld` are high in cycle N+1 with the first guess.
- With `cmp_vld` tied high, there is one probe per cycle. A hit on probe k gives `done` in cycle N+1+k.
- A stall (`cmp_vld=0`) holds `guess`, `guess_vld`, `lo`, `hi` and `iters` unchanged.
- `guess_vld=0` in IDLE and DONE.
- `cmp` is ignored whenever `guess_vld=0`.
- Reset asserted mid-search forces all outputs to their reset values immediately. No `done` pulse is emitted.

## Structure

- Shared package `bsearch_pkg` contains:
  - Compare-code constants `CMP_LT=3'b100`, `CMP_EQ=3'b010`, `CMP_GT=3'b001`.
  - The state enum.
  - Default `W`.
- The block is a single flat module with no sub-module. The comparator is instantiated alongside it in the parent and in the bench.

## Test plan

- **Full range, target 0:** `lo=0`, `hi=1048575`, target 0, comparator combinational -> first guess 524287; `done` after 20 probes; `found=1`, `result=0`, `iters=20`.
- **Full range, target at midpoint:** same range, target 524287 -> `done` in cycle N+2; `iters=1`, `found=1`.
- **Target below range:** `lo=10`, `hi=20`, target 5 -> guesses 15, 12, 10; `found=0`, `iters=3`.
- **Target at maximum:** `lo=0`, `hi=1048575`, target 1048575 -> `found=1`, `result=1048575`; no overflow of `lo`.
- **Stall then illegal code:** `cmp_vld` low for 4 cycles -> `guess` stable; then `cmp=3'b000` with `cmp_vld=1` -> `err=1`, `found=0`, `done` pulses once.
- **Reset mid-search, then inverted bounds:** `rst_n` low at probe 3 -> all outputs 0 immediately. A new start with `lo_in=5`, `hi_in=4` -> `done` in cycle N+1, `found=0`, `iters=0`.
